// File: rtl/mem_arbiter.sv
// mem_arbiter
// Lets the instruction-fetch port (I) and the data-access port (D) share a
// single-port unified memory. Only one transaction is in flight at a time.
// D normally wins. After STARVE_LIMIT consecutive D grants taken while I
// was waiting, I is forced through. A memory that never answers is
// abandoned after TIMEOUT busy cycles. A timed-out read returns ERR_DATA
// and raises err.
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   i_req/i_addr            fetch request (always a read), held until i_ack
//   i_rdata/i_ack           fetch read data and one-cycle completion pulse
//   d_req/d_we/d_addr/
//   d_wdata                 data request, held until d_ack
//   d_rdata/d_ack           data read data and one-cycle completion pulse
//   m_req/m_we/m_addr/
//   m_wdata                 memory request, stable for the whole busy phase
//   m_rdata/m_ready         memory read data and completion strobe
//   busy                    arbiter is not idle
//   err                     pulses together with the ack of a timed-out access
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT = 255,
  parameter logic [DW-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          busy,
  output logic          err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GRANT_D = 3'd1;
  localparam logic [2:0] BUSY_D  = 3'd2;
  localparam logic [2:0] DONE_D  = 3'd3;
  localparam logic [2:0] GRANT_I = 3'd4;
  localparam logic [2:0] BUSY_I  = 3'd5;
  localparam logic [2:0] DONE_I  = 3'd6;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  // The counter starts at zero on the first busy cycle, so the last
  // permitted busy cycle is the one where it reads TIMEOUT-1.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [SW-1:0] starve_cnt;
  logic [7:0]    tmo_cnt;
  logic          grant_d;
  logic          grant_i;
  logic          tmo_hit;

  // D wins unless I is also waiting and has already been passed over
  // STARVE_LIMIT times in a row.
  assign grant_d = d_req && (!i_req || (starve_cnt < STARVE_MAX));
  assign grant_i = i_req && !grant_d;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // The whole datapath is in one registered block, so every output comes
  // straight from a flop. Acks and err default low each cycle, which makes
  // them single-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state <= GRANT_D;
            busy  <= 1'b1;
            // Only D grants taken while I waits count toward starvation.
            if (i_req) begin
              starve_cnt <= (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
            end else begin
              starve_cnt <= '0;
            end
          end else if (grant_i) begin
            state      <= GRANT_I;
            busy       <= 1'b1;
            starve_cnt <= '0;
          end
        end
        GRANT_D: begin
          m_addr  <= d_addr;
          m_we    <= d_we;
          m_wdata <= d_wdata;
          m_req   <= 1'b1;
          tmo_cnt <= '0;
          state   <= BUSY_D;
        end
        GRANT_I: begin
          m_addr  <= i_addr;
          m_we    <= 1'b0;
          m_req   <= 1'b1;
          tmo_cnt <= '0;
          state   <= BUSY_I;
        end
        BUSY_D, BUSY_I: begin
          // A real response wins over a timeout that lands in the same cycle.
          if (m_ready || tmo_hit) begin
            m_req <= 1'b0;
            err   <= !m_ready;
            if (state == BUSY_D) begin
              state <= DONE_D;
              d_ack <= 1'b1;
              if (!m_we) begin
                d_rdata <= m_ready ? m_rdata : ERR_DATA;
              end
            end else begin
              state <= DONE_I;
              i_ack <= 1'b1;
              i_rdata <= m_ready ? m_rdata : ERR_DATA;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE_D, DONE_I: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Randomized bench for mem_arbiter. The reference model works at the
// transaction level. When a request is granted in an idle cycle t with
// busy length L, the arbiter is busy from cycle t+1 to t+2+L. It holds
// m_req from cycle t+2 to t+1+L and acks at cycle t+2+L. Expected outputs
// come from that timeline arithmetic plus the starvation rule.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int STARVE_LIMIT = 3;
  localparam int TIMEOUT = 255;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ready = 1'b0;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy), .err(err)
  );

  int compared = 0;
  int mismatched = 0;

  // Transaction-level model state.
  int          cyc = 0;
  bit          in_txn = 1'b0;
  int          t_start = 0;
  int          lat = 0;
  bit          t_out = 1'b0;
  bit          t_is_d = 1'b0;
  bit          t_we = 1'b0;
  int          starve = 0;
  bit          i_pend = 1'b0;
  bit          d_pend = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;
  logic [31:0] cap_rdata = '0;
  int          req_pct = 30;
  int          tmo_pct = 0;
  int          force_lat = 0;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: observed %08h, expected %08h", tag, cyc, actual, expected);
    end
  endtask

  // One clock cycle: drive requesters and memory, advance the model,
  // then compare every output at the falling edge.
  task automatic apply_stimulus();
    bit exp_busy;
    bit exp_mreq;
    bit ack_now;
    @(posedge clk);
    #1;
    cyc++;

    // The owner of a finished transaction drops or replaces its request
    // on the edge after its ack.
    if (in_txn && cyc > t_start + 2 + lat) begin
      in_txn = 1'b0;
      if (t_is_d) d_pend = 1'b0;
      else        i_pend = 1'b0;
    end

    if (!i_pend && int'($urandom_range(99)) < req_pct) i_pend = 1'b1;
    if (!d_pend && int'($urandom_range(99)) < req_pct) begin
      d_pend = 1'b1;
      d_we   = 1'($urandom_range(1));
    end

    // Address and data may wander until the grant cycle, then must hold.
    if (!(in_txn && !t_is_d && cyc >= t_start + 2)) i_addr = $urandom;
    if (!(in_txn && t_is_d && cyc >= t_start + 2)) begin
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
    if (in_txn && cyc == t_start + 1) begin
      exp_addr  = t_is_d ? d_addr : i_addr;
      exp_wdata = d_wdata;
      t_we      = t_is_d ? d_we : 1'b0;
    end
    i_req = i_pend;
    d_req = d_pend;

    if (!in_txn && (i_pend || d_pend)) begin
      in_txn  = 1'b1;
      t_start = cyc;
      if (d_pend && (!i_pend || starve < STARVE_LIMIT)) begin
        t_is_d = 1'b1;
        starve = i_pend ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
      end else begin
        t_is_d = 1'b0;
        starve = 0;
      end
      t_out = int'($urandom_range(99)) < tmo_pct;
      lat   = t_out ? TIMEOUT : ((force_lat > 0) ? force_lat : int'($urandom_range(1, 6)));
    end

    // Memory answers on the last busy cycle. Strobes outside the busy
    // window are random noise that the arbiter must ignore.
    m_rdata = $urandom;
    if (in_txn && cyc >= t_start + 2 && cyc <= t_start + 1 + lat) begin
      m_ready = !t_out && (cyc == t_start + 1 + lat);
    end else begin
      m_ready = 1'($urandom_range(1));
    end
    if (in_txn && cyc == t_start + 1 + lat) cap_rdata = t_out ? ERR_DATA : m_rdata;

    @(negedge clk);
    exp_busy = in_txn && cyc >= t_start + 1;
    exp_mreq = in_txn && cyc >= t_start + 2 && cyc <= t_start + 1 + lat;
    ack_now  = in_txn && cyc == t_start + 2 + lat;
    if (ack_now && !t_we) begin
      if (t_is_d) exp_d_rdata = cap_rdata;
      else        exp_i_rdata = cap_rdata;
    end

    check_output("busy", 32'(busy), 32'(exp_busy));
    check_output("m_req", 32'(m_req), 32'(exp_mreq));
    check_output("i_ack", 32'(i_ack), 32'(ack_now && !t_is_d));
    check_output("d_ack", 32'(d_ack), 32'(ack_now && t_is_d));
    check_output("err", 32'(err), 32'(ack_now && t_out));
    check_output("i_rdata", i_rdata, exp_i_rdata);
    check_output("d_rdata", d_rdata, exp_d_rdata);
    if (exp_mreq) begin
      check_output("m_addr", m_addr, exp_addr);
      check_output("m_we", 32'(m_we), 32'(t_we));
      if (t_is_d) check_output("m_wdata", m_wdata, exp_wdata);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_m_req"}, 32'(m_req), 32'd0);
    check_output({tag, "_m_we"}, 32'(m_we), 32'd0);
    check_output({tag, "_i_ack"}, 32'(i_ack), 32'd0);
    check_output({tag, "_d_ack"}, 32'(d_ack), 32'd0);
    check_output({tag, "_err"}, 32'(err), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_m_addr"}, m_addr, 32'd0);
    check_output({tag, "_m_wdata"}, m_wdata, 32'd0);
    check_output({tag, "_i_rdata"}, i_rdata, 32'd0);
    check_output({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  // Start a long D read, then pull reset asynchronously partway through
  // the busy phase. The transaction must vanish without an ack.
  task automatic reset_mid_busy();
    int guard;
    req_pct   = 0;
    tmo_pct   = 0;
    force_lat = 20;
    guard     = 0;
    while (!(in_txn && t_is_d && lat == 20 && cyc >= t_start + 3 && cyc <= t_start + 1 + lat)
           && guard < 500) begin
      if (!in_txn && !d_pend) begin
        d_pend = 1'b1;
        d_we   = 1'b0;
      end
      apply_stimulus();
      guard++;
    end
    check_output("reset_setup_reached", 32'(guard < 500), 32'd1);

    #2;
    reset = 1'b0;
    #1;
    check_output("rst_async_m_req", 32'(m_req), 32'd0);
    check_output("rst_async_busy", 32'(busy), 32'd0);
    check_output("rst_async_d_ack", 32'(d_ack), 32'd0);

    in_txn      = 1'b0;
    starve      = 0;
    i_pend      = 1'b0;
    d_pend      = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    force_lat   = 0;
    i_req       = 1'b0;
    d_req       = 1'b0;
    m_ready     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst_hold");
    reset = 1'b1;
  endtask

  initial begin
    $display("[TB] mem_arbiter randomized run starting");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;

    req_pct = 30; tmo_pct = 0;
    repeat (300) apply_stimulus();

    // Both ports always requesting exercises the D,D,D,I rotation.
    req_pct = 100;
    repeat (200) apply_stimulus();

    req_pct = 50; tmo_pct = 100;
    repeat (600) apply_stimulus();

    req_pct = 40; tmo_pct = 0;
    repeat (60) apply_stimulus();

    reset_mid_busy();

    // Immediately after reset, the starvation count must restart from zero.
    req_pct = 100;
    repeat (100) apply_stimulus();

    req_pct = 60; tmo_pct = 2;
    repeat (1500) apply_stimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port (I) and its data-access port (D).
- Sits between the processor core and the memory.
- Arbitrates on a registered, one-transaction-at-a-time basis, with data priority, a fetch starvation guard and a memory-response timeout.
- Requesters use a req/ack handshake; the memory side tolerates variable latency through m_ready.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_LIMIT, 3, consecutive D grants allowed while I is waiting before I is forced.
- TIMEOUT, 255, cycles in BUSY without m_ready before the transaction is aborted (8-bit counter).
- ERR_DATA, 32'hDEADBEEF, read data returned on a timed-out read.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetch read data, valid while i_ack=1
- i_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_rdata  out  DW  data read data, valid while d_ack=1
- d_ack  out  1  one-cycle data completion pulse
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid with m_ready
- m_ready  in  1  memory completion
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse coincident with the ack of a timed-out transaction

Behaviour:
- Reset (reset=0, async):
  - State forced to IDLE.
  - Outputs cleared: m_req, m_we, i_ack, d_ack, err, busy = 0; m_addr, m_wdata, i_rdata, d_rdata = 0.
  - Starvation and timeout counters cleared.
  - A reset mid-transaction abandons it silently: no ack, no err.
- States and transitions:
  - IDLE → GRANT_D or GRANT_I when a request is present.
  - GRANT_x → BUSY_x.
  - BUSY_x → DONE_x.
  - DONE_x → IDLE.
  - The state, all outputs and all counters are registered.
- IDLE arbitration:
  - If d_req=1 and (i_req=0 or starve_cnt<STARVE_LIMIT): grant D.
  - Else if i_req=1: grant I.
  - Else remain in IDLE.
  - On a D grant with i_req=1: starve_cnt increments, saturating at STARVE_LIMIT.
  - On an I grant: starve_cnt clears.
  - On any D grant with i_req=0: starve_cnt clears.
- GRANT_x (one cycle): latch addr, we (D only; I is always read) and wdata into m_addr/m_we/m_wdata. m_req rises on exit, so it is 1 throughout BUSY_x.
- BUSY_x:
  - m_req=1 with address, we and wdata stable.
  - The timeout counter counts cycles.
  - On m_ready=1: m_req drops at the next edge; for reads, x_rdata captures m_rdata; go to DONE_x.
  - If the count reaches TIMEOUT with no m_ready: m_req drops; for reads, x_rdata = ERR_DATA; err=1 in DONE_x.
- DONE_x (one cycle): x_ack=1, busy=1. x_rdata holds until the next read completion on that port.
- Writes do not modify x_rdata.
- Timing:
  - Minimum latency: request sampled in IDLE at cycle 0, ack at cycle 3 with m_ready at the first BUSY cycle.
  - Back-to-back issue interval is 4 cycles.
  - Requesters must deassert or change req on the edge after ack. The arbiter ignores req in every state except IDLE.
- Address/data changes while a request is pending but not yet granted are permitted; the values at the GRANT_x cycle are used.
- Simultaneous i_req and d_req with starve_cnt=STARVE_LIMIT: I wins.
- m_ready outside BUSY_x is ignored.

Test Plan:
- D read alone: d_req=1, d_addr=0x40, m_ready=1 on the first BUSY cycle, m_rdata=0x12345678 → m_req high for 1 cycle with m_addr=0x40, m_we=0; d_ack pulse at cycle 3 with d_rdata=0x12345678; i_ack stays 0.
- Contention/starvation: i_req and d_req held continuously with 1-cycle memory → grant order D,D,D,I,D,D,D,I; each ack lasts exactly one cycle.
- D write with 5-cycle memory latency: d_we=1, d_wdata=0xCAFEF00D → m_req=1 for 5 cycles with stable m_wdata/m_we=1; d_ack one cycle after m_ready; d_rdata unchanged from its prior value.
- Timeout, I read: m_ready never asserted → after 255 BUSY cycles m_req drops; i_ack and err pulse together; i_rdata=0xDEADBEEF; the next D request proceeds normally.
- Async reset mid-BUSY: reset=0 asynchronously during BUSY_D → m_req, d_ack, busy go 0 immediately with no ack afterwards; after release a fresh i_req completes normally with starve_cnt=0.
- Late m_ready: m_ready pulsed in IDLE and in DONE → no effect on state, acks or rdata.
